time_display_scan: RTL and testbench

Downstream display stage for the digital clock's hour/minute/second counter. Samples the binary `hour`, `minute` and `second` values once per display frame and converts them to BCD with a sequential subtract-ten engine. Drives a 6-digit common-anode seven-segment display by time-multiplexed scanning in the order HH MM SS. Runs on the fast board clock, not on the 1 Hz counter tick.

---
 rtl/time_display_scan.sv | 160 ++++++++++++++++
 tb/tb_time_display_scan.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/time_display_scan.sv
// Six-digit HH MM SS seven-segment scanner with a sequential binary-to-BCD converter.
// Optional build macro COLON_BLINK_EN gates the hour/minute separators with snapshot second[0].
module time_display_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       signal,
  input  logic       clr,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       blank,
  output logic [5:0] dig_sel,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [3:0] DASH = 4'hF;

  typedef enum logic [2:0] {IDLE, LOAD, CONV_H, CONV_M, CONV_S, COMMIT} state_t;

  logic [PW-1:0]   pre_q, pre_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0]      dig_sel_q, dig_sel_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  state_t          state_q;
  logic [4:0]      snap_h_q;
  logic [5:0]      snap_m_q, snap_s_q;
  logic [5:0]      work_q;
  logic [2:0]      tens_q;
  logic [5:0][3:0] bcd_q, disp_q;   // [0] = hour tens ... [5] = second units
  logic            frame_start, ge10, oor_h, oor_m, oor_s, sep;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      default: glyph = 7'b1111110;
    endcase
  endfunction

  assign frame_start = (pre_q == '0) && (idx_q == '0);
  assign ge10        = (work_q >= 6'd10);
  assign oor_h       = (snap_h_q >= 5'd24);
  assign oor_m       = (snap_m_q >= 6'd60);
  assign oor_s       = (snap_s_q >= 6'd60);

  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_comb begin
    sep = (idx_q == 3'd1) || (idx_q == 3'd3);
`ifdef COLON_BLINK_EN
    sep = sep && !snap_s_q[0];
`endif
    dig_sel_d = ~(6'b100000 >> idx_q);
    seg_d     = glyph(disp_q[idx_q]);
    dp_d      = ~sep;
    if (blank) begin
      dig_sel_d = 6'b111111;
      seg_d     = 7'b1111111;
      dp_d      = 1'b1;
    end
  end

  always_ff @(posedge signal) begin
    if (clr) begin
      pre_q     <= '0;
      idx_q     <= '0;
      dig_sel_q <= 6'b111111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      dig_sel_q <= dig_sel_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  // Converter: one subtract-ten per cycle; out-of-range fields become dash codes at store time.
  always_ff @(posedge signal) begin
    if (clr) begin
      state_q  <= IDLE;
      snap_h_q <= '0;
      snap_m_q <= '0;
      snap_s_q <= '0;
      work_q   <= '0;
      tens_q   <= '0;
      bcd_q    <= '0;
      disp_q   <= '0;
    end else begin
      if (frame_start) begin
        snap_h_q <= hour;
        snap_m_q <= minute;
        snap_s_q <= second;
      end
      case (state_q)
        IDLE: if (frame_start) state_q <= LOAD;
        LOAD: begin
          work_q  <= {1'b0, snap_h_q};
          tens_q  <= '0;
          state_q <= CONV_H;
        end
        CONV_H: if (ge10) begin
          work_q <= work_q - 6'd10;
          tens_q <= tens_q + 3'd1;
        end else begin
          bcd_q[0] <= oor_h ? DASH : {1'b0, tens_q};
          bcd_q[1] <= oor_h ? DASH : work_q[3:0];
          work_q   <= snap_m_q;
          tens_q   <= '0;
          state_q  <= CONV_M;
        end
        CONV_M: if (ge10) begin
          work_q <= work_q - 6'd10;
          tens_q <= tens_q + 3'd1;
        end else begin
          bcd_q[2] <= oor_m ? DASH : {1'b0, tens_q};
          bcd_q[3] <= oor_m ? DASH : work_q[3:0];
          work_q   <= snap_s_q;
          tens_q   <= '0;
          state_q  <= CONV_S;
        end
        CONV_S: if (ge10) begin
          work_q <= work_q - 6'd10;
          tens_q <= tens_q + 3'd1;
        end else begin
          bcd_q[4] <= oor_s ? DASH : {1'b0, tens_q};
          bcd_q[5] <= oor_s ? DASH : work_q[3:0];
          state_q  <= COMMIT;
        end
        COMMIT: begin
          disp_q  <= bcd_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dig_sel = dig_sel_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
endmodule

// File: tb/tb_time_display_scan.sv
// Randomized bench for time_display_scan with a frame-level reference model of the scanned display.
module tb_time_display_scan;
  localparam int SD = 32;
  localparam int FR = 6 * SD;

  logic       signal = 1'b0;
  logic       clr = 1'b1;
  logic       blank = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] minute = '0;
  logic [5:0] second = '0;
  logic [5:0] dig_sel;
  logic [6:0] seg;
  logic       dp;

  int n_tests = 0;
  int n_fail  = 0;
  int t = 0;
  bit fresh = 1'b1;
  int sh = 0, sm = 0, ss = 0;

  time_display_scan #(.SCAN_DIV(SD)) dut (
    .signal(signal), .clr(clr), .hour(hour), .minute(minute), .second(second),
    .blank(blank), .dig_sel(dig_sel), .seg(seg), .dp(dp)
  );

  always #5 signal = ~signal;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [6:0] digit_glyph(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  // Position 0..5 reads HH MM SS left to right; a field past its limit shows dashes.
  function automatic logic [6:0] exp_seg(input int pos, input int h, input int m, input int s);
    int v, lim;
    v   = (pos < 2) ? h : (pos < 4) ? m : s;
    lim = (pos < 2) ? 24 : 60;
    if (v >= lim) return 7'b1111110;
    return digit_glyph((pos % 2 == 0) ? v / 10 : v % 10);
  endfunction

  task automatic check_outputs(input bit b);
    int pos, fo;
    logic [5:0] e_sel;
    bit lit;
    pos = (t / SD) % 6;
    fo  = t % FR;
    if (b) begin
      chk("blank_dig", 32'(dig_sel), 32'h3F);
      chk("blank_seg", 32'(seg), 32'h7F);
      chk("blank_dp", 32'(dp), 32'h1);
    end else begin
      e_sel = ~(6'b100000 >> pos);
      lit = (pos == 1) || (pos == 3);
`ifdef COLON_BLINK_EN
      lit = lit && (ss % 2 == 0);
`endif
      chk("dig_sel", 32'(dig_sel), 32'(e_sel));
      chk("dp", 32'(dp), 32'(!lit));
      if (fo >= 22) chk("seg", 32'(seg), 32'(exp_seg(pos, sh, sm, ss)));
      else if (fresh && fo == 0) chk("seg_rst0", 32'(seg), 32'(7'b0000001));
    end
  endtask

  task automatic step();
    bit c, b;
    c = clr;
    b = blank;
    if (!c && (t % FR == 0)) begin
      sh = int'(hour); sm = int'(minute); ss = int'(second);
    end
    @(posedge signal);
    #1;
    if (c) begin
      chk("clr_dig", 32'(dig_sel), 32'h3F);
      chk("clr_seg", 32'(seg), 32'h7F);
      chk("clr_dp", 32'(dp), 32'h1);
      t = 0;
      fresh = 1'b1;
    end else begin
      check_outputs(b);
      t++;
      if (t == FR) fresh = 1'b0;
    end
  endtask

  initial begin
    hour = 5'd23; minute = 6'd59; second = 6'd58;
    clr = 1'b1;
    repeat (3) step();
    clr = 1'b0;
    repeat (2 * FR) step();

    // minute changes mid-frame at minute-units slot, pre = 10
    for (int i = 0; i < FR && (t % FR) != 3 * SD + 10; i++) step();
    minute = 6'd0;
    repeat (2 * FR) step();

    hour = 5'd7; minute = 6'd60; second = 6'd5;
    repeat (2 * FR) step();

    second = 6'd4;
    repeat (2 * FR) step();
    second = 6'd5;
    repeat (2 * FR) step();

    blank = 1'b1;
    repeat (100) step();
    blank = 1'b0;
    repeat (FR) step();

    // clr lands while the minute field is being converted
    hour = 5'd23; minute = 6'd59; second = 6'd58;
    for (int i = 0; i < FR && (t % FR) != 0; i++) step();
    repeat (8) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (2 * FR) step();

    for (int i = 0; i < 20 * FR; i++) begin
      if ($urandom_range(0, 39) == 0) hour = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) minute = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0) second = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 299) == 0) blank = ~blank;
      clr = ($urandom_range(0, 1999) == 0);
      step();
    end
    clr = 1'b0;
    blank = 1'b0;
    repeat (FR) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
